// File: rtl/timer_output_monitor.sv
// -----------------------------------------------------------------------------
// timer_output_monitor
//
// Period checker for the two-channel programmable timer. Each channel watches
// its divided-clock output while its gate is open, measures the distance in
// clk cycles between rising edges, and compares it with the expected divisor.
//
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   g0, g1              channel gates; measurement only while high
//   out0, out1          timer divided-clock outputs (synchronous to clk)
//   exp0, exp1          expected period in cycles, 0 encodes 16
//   clr_err             synchronous clear of err_cnt
//   period0, period1    last completed period (saturates at 2^CNT_W-1)
//   valid0, valid1      one-cycle pulse when period* updates
//   mismatch0/1         one-cycle pulse with valid* when period != expected
//   stall0, stall1      gate open but no rising edge for TIMEOUT cycles
//   err_cnt             saturating count of mismatches on both channels
// -----------------------------------------------------------------------------
module timer_output_monitor #(
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             g0,
    input  logic             g1,
    input  logic             out0,
    input  logic             out1,
    input  logic [3:0]       exp0,
    input  logic [3:0]       exp1,
    input  logic             clr_err,
    output logic [CNT_W-1:0] period0,
    output logic [CNT_W-1:0] period1,
    output logic             valid0,
    output logic             valid1,
    output logic             mismatch0,
    output logic             mismatch1,
    output logic             stall0,
    output logic             stall1,
    output logic [7:0]       err_cnt
);

    typedef enum logic [1:0] {IDLE, ARMED, MEASURE} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    // Channel inputs gathered into arrays so both channels share one body.
    logic [1:0]       gate;
    logic [1:0]       outs;
    logic [3:0]       exp_v   [2];

    state_t           state   [2];
    logic [1:0]       prev;
    logic [CNT_W-1:0] cnt     [2];
    logic [CNT_W-1:0] period  [2];
    logic [1:0]       valid;
    logic [1:0]       mismatch;
    logic [1:0]       stall;

    logic [1:0]       rise;
    logic [1:0]       mis_next;
    logic [CNT_W-1:0] cnt_inc [2];
    logic [CNT_W-1:0] exp_e   [2];
    logic [8:0]       err_sum;

    assign gate     = {g1, g0};
    assign outs     = {out1, out0};
    assign exp_v[0] = exp0;
    assign exp_v[1] = exp1;

    // NOTE: every always_comb output gets a default first so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    always_comb begin
        rise     = '0;
        mis_next = '0;
        cnt_inc  = '{default: '0};
        exp_e    = '{default: '0};
        for (int n = 0; n < 2; n++) begin
            rise[n]    = outs[n] & ~prev[n];
            exp_e[n]   = (exp_v[n] == 4'd0) ? CNT_W'(16) : CNT_W'(exp_v[n]);
            cnt_inc[n] = (cnt[n] == CNT_MAX) ? cnt[n] : cnt[n] + 1'b1;
            // Gate low wins over a coincident rise, so it masks the mismatch.
            mis_next[n] = gate[n] && rise[n] && (state[n] == MEASURE) &&
                          (cnt[n] != exp_e[n]);
        end
    end

    // Both channels' next mismatch values feed the counter so that err_cnt
    // moves on the same edge that mismatch* becomes visible.
    assign err_sum = {1'b0, err_cnt} + 9'(mis_next[0]) + 9'(mis_next[1]);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: every register here is small control state and is
            // cleared by reset; there is no memory array left unreset.
            prev     <= '0;
            valid    <= '0;
            mismatch <= '0;
            stall    <= '0;
            for (int n = 0; n < 2; n++) begin
                state[n]  <= IDLE;
                cnt[n]    <= '0;
                period[n] <= '0;
            end
        end else begin
            prev     <= outs;
            valid    <= '0;
            mismatch <= '0;
            for (int n = 0; n < 2; n++) begin
                case (state[n])
                    IDLE: begin
                        cnt[n]   <= '0;
                        stall[n] <= 1'b0;
                        if (gate[n]) state[n] <= ARMED;
                    end
                    ARMED, MEASURE: begin
                        if (!gate[n]) begin
                            // Partial count is dropped; no valid pulse.
                            state[n] <= IDLE;
                            cnt[n]   <= '0;
                            stall[n] <= 1'b0;
                        end else if (rise[n]) begin
                            // The rise edge itself is cycle 1 of the next period.
                            cnt[n]   <= CNT_W'(1);
                            stall[n] <= 1'b0;
                            if (state[n] == MEASURE) begin
                                period[n]   <= cnt[n];
                                valid[n]    <= 1'b1;
                                mismatch[n] <= mis_next[n];
                            end
                            state[n] <= MEASURE;
                        end else begin
                            cnt[n] <= cnt_inc[n];
                            if (cnt_inc[n] == TIMEOUT_C) stall[n] <= 1'b1;
                        end
                    end
                    default: state[n] <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (clr_err) begin
            err_cnt <= '0;
        end else begin
            err_cnt <= (err_sum > 9'd255) ? 8'd255 : err_sum[7:0];
        end
    end

    assign period0   = period[0];
    assign period1   = period[1];
    assign valid0    = valid[0];
    assign valid1    = valid[1];
    assign mismatch0 = mismatch[0];
    assign mismatch1 = mismatch[1];
    assign stall0    = stall[0];
    assign stall1    = stall[1];

endmodule
